// File: rtl/fp16_pkg.sv
// Shared FP16 types and constants for the dot-product datapath.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    REDUCE,
    RESULT
  } dot_state_t;

endpackage

// File: rtl/fma_issue_tracker.sv
// Remembers which FMA issues belong to this block, so that only those results are consumed.
// Anything still in the FMA pipe from before a reset or a clear is reported as not own.
module fma_issue_tracker #(
  parameter int unsigned LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic clear,
  output logic own
);

  logic [LAT-1:0] bits_q, bits_d;

  // Shift one issue bit per cycle; the bit leaving the top lines up with its FMA result.
  always_comb begin
    bits_d = {bits_q[LAT-2:0], issue};
    if (clear) begin
      bits_d = '0;
    end
  end

  // Tracker register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign own = bits_q[LAT-1];

endmodule

// File: rtl/fp16_dot_accum_seq.sv
// Streaming FP16 dot-product sequencer. Rotates accumulation among LAT partial-sum slots to
// hide the FMA latency, then drains the pipe and folds the partials with a serial chain of
// r*1.0 + acc[k] operations through the same FMA.
module fp16_dot_accum_seq
  import fp16_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic        fma_valid,
  output logic [15:0] fma_a,
  output logic [15:0] fma_b,
  output logic [15:0] fma_c,
  input  logic        fma_out_valid,
  input  logic [15:0] fma_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum
);

  localparam int unsigned PtrW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned CntW = $clog2(LAT + 1);

  dot_state_t      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_next;
  fp16_t           acc_q [LAT];
  fp16_t           acc_d [LAT];
  logic [CntW-1:0] cnt_q, cnt_d;
  // Index of the next partial to fold in during REDUCE; 0 means the chain has not started.
  logic [CntW-1:0] red_k_q, red_k_d;
  fp16_t           out_sum_q, out_sum_d;
  logic            own;
  logic            trk_clear;
  fp16_t           cur;

  fma_issue_tracker #(
    .LAT (LAT)
  ) u_tracker (
    .clk   (clk),
    .rst   (rst),
    .issue (fma_valid),
    .clear (trk_clear),
    .own   (own)
  );

  assign ptr_next = (ptr_q == PtrW'(LAT - 1)) ? '0 : ptr_q + PtrW'(1);
  // A returning own result is the freshest value of the slot it was issued from.
  assign cur      = own ? fma_out : acc_q[ptr_q];
  assign out_sum  = out_sum_q;

  // Next-state, slot update and FMA issue decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    red_k_d   = red_k_q;
    out_sum_d = out_sum_q;
    in_ready  = 1'b0;
    fma_valid = 1'b0;
    fma_a     = FP16_ZERO;
    fma_b     = FP16_ZERO;
    fma_c     = FP16_ZERO;
    out_valid = 1'b0;
    trk_clear = 1'b0;

    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        ptr_d    = ptr_next;
        if (own) begin
          acc_d[ptr_q] = fma_out;
        end
        if (in_valid) begin
          fma_valid = 1'b1;
          fma_a     = in_a;
          fma_b     = in_b;
          fma_c     = cur;
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CntW'(LAT);
          end
        end
      end

      DRAIN: begin
        ptr_d = ptr_next;
        if (own) begin
          acc_d[ptr_q] = fma_out;
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = REDUCE;
          red_k_d = '0;
        end
      end

      REDUCE: begin
        if (red_k_q == '0) begin
          fma_valid = 1'b1;
          fma_a     = acc_q[0];
          fma_b     = FP16_ONE;
          fma_c     = acc_q[1];
          red_k_d   = CntW'(2);
        end else if (own) begin
          if (red_k_q == CntW'(LAT)) begin
            out_sum_d = fma_out;
            state_d   = RESULT;
          end else begin
            // Chain the next op off the result arriving this very cycle.
            fma_valid = 1'b1;
            fma_a     = fma_out;
            fma_b     = FP16_ONE;
            fma_c     = acc_q[red_k_q[PtrW-1:0]];
            red_k_d   = red_k_q + CntW'(1);
          end
        end
      end

      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          for (int k = 0; k < LAT; k++) begin
            acc_d[k] = FP16_ZERO;
          end
          ptr_d     = '0;
          trk_clear = 1'b1;
          state_d   = ACCUM;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      ptr_q     <= '0;
      cnt_q     <= '0;
      red_k_q   <= '0;
      out_sum_q <= FP16_ZERO;
      for (int k = 0; k < LAT; k++) begin
        acc_q[k] <= FP16_ZERO;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      red_k_q   <= red_k_d;
      out_sum_q <= out_sum_d;
      acc_q     <= acc_d;
    end
  end

  // Every result the tracker claims must actually be presented by the FMA.
  a_own_has_valid : assert property (@(posedge clk) disable iff (rst) own |-> fma_out_valid);

endmodule

// File: tb/tb_fp16_dot_accum_seq.sv
// Directed bench for fp16_dot_accum_seq with a behavioural fixed-latency FMA model.
module tb_fp16_dot_accum_seq;
  import fp16_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int RES_LAT = LAT * LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        fma_valid;
  logic [15:0] fma_a, fma_b, fma_c;
  logic        fma_out_valid;
  logic [15:0] fma_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;

  int cyc = 0;
  int t_acc = 0;
  int n_vec = 0;
  int n_miss = 0;

  fp16_dot_accum_seq #(
    .LAT (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_last       (in_last),
    .fma_valid     (fma_valid),
    .fma_a         (fma_a),
    .fma_b         (fma_b),
    .fma_c         (fma_c),
    .fma_out_valid (fma_out_valid),
    .fma_out       (fma_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    if (e == 0) v = real'(m) * pow2(-24);
    else v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Good enough for the normal, exactly representable values this bench produces.
  function automatic logic [15:0] real_to_fp16(input real x);
    logic s = 1'b0;
    int e = 15;
    int m;
    real r = x;
    if (r == 0.0) return 16'h0000;
    if (r < 0.0) begin s = 1'b1; r = -r; end
    for (int i = 0; i < 40 && r >= 2.0; i++) begin r = r / 2.0; e++; end
    for (int i = 0; i < 40 && r < 1.0; i++) begin r = r * 2.0; e--; end
    m = $rtoi((r - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  // Behavioural FMA: result and valid appear exactly LAT cycles after the issue cycle.
  logic [15:0] pipe_d [LAT];
  logic [LAT-1:0] pipe_v = '0;
  initial for (int i = 0; i < LAT; i++) pipe_d[i] = '0;
  always @(posedge clk) begin
    pipe_v <= {pipe_v[LAT-2:0], fma_valid};
    pipe_d[0] <= real_to_fp16(fp16_to_real(fma_a) * fp16_to_real(fma_b) + fp16_to_real(fma_c));
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign fma_out_valid = pipe_v[LAT-1];
  assign fma_out       = pipe_d[LAT-1];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one pair starting just after a posedge; returns just after its accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    while (!in_ready && guard < 60) begin @(negedge clk); guard++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait for the result, check value/latency/stall behaviour, then complete the handshake.
  task automatic await_result(input string name, input logic [15:0] exp, input int hold);
    int guard = 0;
    bit ir_bad = 1'b0;
    bit hold_bad = 1'b0;
    @(negedge clk);
    while (!out_valid && guard < 60) begin
      if (in_ready) ir_bad = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, 0, 1);
      @(posedge clk); #1;
      return;
    end
    chk({name, "_latency"}, cyc - t_acc, RES_LAT);
    chk({name, "_sum"}, int'(out_sum), int'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid || out_sum !== exp || in_ready) hold_bad = 1'b1;
    end
    if (hold > 0) chk({name, "_stall_stable"}, int'(hold_bad), 0);
    chk({name, "_in_ready_low"}, int'(ir_bad | in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_back_to_accum"}, int'({in_ready, out_valid}), 2);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    bit          gaps;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0].name = "four_pairs";  vecs[0].n = 4; vecs[0].a = 16'h3C00; vecs[0].b = 16'h4000;
    vecs[0].gaps = 1'b0; vecs[0].exp = 16'h4800;
    vecs[1].name = "single_pair"; vecs[1].n = 1; vecs[1].a = 16'h4200; vecs[1].b = 16'h4000;
    vecs[1].gaps = 1'b0; vecs[1].exp = 16'h4600;
    vecs[2].name = "bubbles";     vecs[2].n = 6; vecs[2].a = 16'h3800; vecs[2].b = 16'h4000;
    vecs[2].gaps = 1'b1; vecs[2].exp = 16'h4600;
    vecs[3].name = "nine_wrap";   vecs[3].n = 9; vecs[3].a = 16'h3C00; vecs[3].b = 16'h3C00;
    vecs[3].gaps = 1'b0; vecs[3].exp = 16'h4880;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_fma_valid", int'(fma_valid), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sum", int'(out_sum), 0);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].a, vecs[v].b, i == vecs[v].n - 1);
        if (vecs[v].gaps && i < vecs[v].n - 1) begin
          @(posedge clk); #1;
        end
      end
      await_result(vecs[v].name, vecs[v].exp, 0);
    end

    // Downstream stalls five cycles; the following vector must start clean.
    for (int i = 0; i < 4; i++) send(16'h3C00, 16'h4000, i == 3);
    await_result("stall", 16'h4800, 5);
    send(16'h3C00, 16'h3C00, 1'b1);
    await_result("after_stall", 16'h3C00, 0);

    // Reset in DRAIN with three results still in the FMA pipe.
    for (int i = 0; i < 3; i++) send(16'h3C00, 16'h4000, i == 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_sum", int'(out_sum), 0);
    @(posedge clk); #1;
    send(16'h4000, 16'h4000, 1'b1);
    await_result("after_rst", 16'h4400, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fp16_dot_accum_seq.md
# fp16_dot_accum_seq

Streaming dot-product sequencer that sits directly upstream of the 4-cycle FP16 fused multiply-add unit and owns its operand ports. It accepts (a, b) FP16 pairs with a ready/valid handshake and hides FMA latency by rotating among LAT interleaved partial sums. On the last element it drains the pipe, reduces the partials through the same FMA, and presents one FP16 sum downstream.

## Interface
- LAT, 4: FMA issue-to-result latency in cycles, and also the number of partial-sum slots; must be ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_a, in_b  in  16  FP16 operands.
- in_last  in  1  marks the final pair of a vector; sampled on acceptance.
- fma_valid  out  1  FMA issue strobe.
- fma_a, fma_b, fma_c  out  16  FMA operands; the FMA computes a*b+c.
- fma_out_valid  in  1  FMA result valid; used only for assertion checking.
- fma_out  in  16  FMA result, valid exactly LAT cycles after the issue.
- out_valid  out  1  dot-product result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  16  FP16 dot product.

## Operation
- States: ACCUM, DRAIN, REDUCE, RESULT. Reset enters ACCUM.
- Reset values:
  - ptr=0 and all acc[k]=0x0000.
  - issue tracker cleared.
  - in_ready=1, fma_valid=0, out_valid=0, out_sum=0x0000.
- ptr advances modulo LAT on every cycle of ACCUM and DRAIN.
- The issue tracker is a LAT-deep shift of issue bits. A returning result is "own" iff the tracker bit emerging this cycle is 1.
  - Results that are not own are ignored. This covers stale results after a reset.
- Slot value: cur = own ? fma_out : acc[ptr]. The result returns to the same slot that issued it.
- ACCUM:
  - in_ready=1.
  - On an accepted pair: issue a=in_a, b=in_b, c=cur.
  - With no accepted pair: no issue. If own, write acc[ptr]=fma_out.
  - If in_last is accepted: go to DRAIN with cnt=LAT.
- DRAIN:
  - in_ready=0, no issue, own results are written back.
  - Decrement cnt; at cnt==1 go to REDUCE.
- REDUCE:
  - Serial chain: r=acc[0]. For k=1..LAT-1, issue a=r, b=0x3C00 (1.0), c=acc[k].
  - r for the next op is fma_out when the own result returns; the next op issues in that same cycle.
  - LAT-1 ops in total, spaced LAT cycles apart.
  - The final own result is registered into out_sum. Go to RESULT.
- RESULT:
  - out_valid=1 and out_sum held stable until out_valid&out_ready.
  - Then clear all acc to 0x0000, set ptr=0, go to ACCUM.
  - in_ready stays 0 during the handshake cycle.
- FP16 arithmetic, including specials, inf and rounding, is entirely the FMA's. This block never inspects values.
- rst mid-operation, in any state: return to reset values immediately. The next vector starts clean.

## Timing
- The issue cycle equals the acceptance cycle; there is no input register.
- Throughput in ACCUM is one pair per cycle, with gaps allowed.
- Let the last pair be accepted at cycle t:
  - DRAIN covers t+1..t+LAT.
  - REDUCE op k issues at t+LAT+1+(k-1)·LAT.
  - The final result returns at t+LAT+1+(LAT-1)·LAT.
  - out_valid rises one cycle after that: t+18 for LAT=4.
- The earliest new acceptance is the cycle after the out handshake.
- Assertion: fma_out_valid is 1 whenever the tracker marks a result as own.

## Structure
- Shared package fp16_pkg:
  - fp16_t (16-bit typedef).
  - FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
  - Enum dot_state_t {ACCUM, DRAIN, REDUCE, RESULT}.
- Sub-module fma_issue_tracker: parameter LAT; inputs issue and clear; output own. A shift register reset by rst.
- A top-level wrapper connecting this block to FP16FMA is a separate file.

## Test plan
The bench uses a behavioural FMA model with exact LAT latency.
- Four pairs (0x3C00,0x4000), back-to-back, last on the 4th → out_sum=0x4800 (8.0) at t+18.
- Single pair (0x4200,0x4000) with last → out_sum=0x4600 (6.0). Unused slots contribute +0.
- Six pairs of (0x3800,0x4000), with in_valid low on alternate cycles → out_sum=0x4600 (6.0). Confirms bubble write-back keeps every slot intact.
- out_ready held low 5 cycles in RESULT → out_sum stable and in_ready=0 throughout. Then the next vector (0x3C00,0x3C00) last → 0x3C00.
- rst asserted during DRAIN with results in flight, then (0x4000,0x4000) last → out_sum=0x4400 (4.0). Stale results are ignored.
- Nine pairs (0x3C00,0x3C00), so ptr wraps twice → out_sum=0x4880 (9.0).
